// File: rtl/sound_pkg.sv
// Shared sound package: register addresses, read masks, NR52 reserved bits.
package sound_pkg;

    localparam logic [15:0] SND_NR10_ADDR = 16'hFF10;
    localparam logic [15:0] SND_NR11_ADDR = 16'hFF11;
    localparam logic [15:0] SND_NR12_ADDR = 16'hFF12;
    localparam logic [15:0] SND_NR13_ADDR = 16'hFF13;
    localparam logic [15:0] SND_NR14_ADDR = 16'hFF14;
    localparam logic [15:0] SND_NR50_ADDR = 16'hFF24;
    localparam logic [15:0] SND_NR51_ADDR = 16'hFF25;
    localparam logic [15:0] SND_NR52_ADDR = 16'hFF26;

    localparam logic [7:0] SND_NR10_RMASK = 8'h80;
    localparam logic [7:0] SND_NR11_RMASK = 8'h3F;
    localparam logic [7:0] SND_NR12_RMASK = 8'h00;
    localparam logic [7:0] SND_NR13_RMASK = 8'hFF;
    localparam logic [7:0] SND_NR14_RMASK = 8'hBF;
    localparam logic [7:0] SND_NR50_RMASK = 8'h00;
    localparam logic [7:0] SND_NR51_RMASK = 8'h00;

    localparam logic [5:0] SND_NR52_RSVD = 6'b111000;
    localparam logic [7:0] SND_UNMAPPED = 8'hFF;

endpackage

// File: rtl/sound_trigger_pulse.sv
// One-cycle trigger pulse from a decoded write strobe and data bit, gated by power.
module sound_trigger_pulse (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_strobe,
    input  logic i_bit,
    input  logic i_power,
    output logic o_pulse
);

    logic r_pulse;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_pulse <= 1'b0;
        else
            r_pulse <= i_strobe & i_bit & i_power;
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/sound_ch1_regfile.sv
// Channel 1 + NR50/51/52 CPU register file.
// Optional macro SOUND_READMASK_EN applies DMG read OR-masks.
module sound_ch1_regfile
    import sound_pkg::*;
(
    input  logic        iClock,
    input  logic        iReset,
    input  logic [15:0] iAddr,
    input  logic        iWe,
    input  logic [7:0]  iData,
    output logic [7:0]  oData,
    output logic [7:0]  oNR10,
    output logic [7:0]  oNR11,
    output logic [7:0]  oNR12,
    output logic [7:0]  oNR13,
    output logic [7:0]  oNR14,
    output logic [7:0]  oNR50,
    output logic [7:0]  oNR51,
    input  logic        iCh1On,
    output logic        oPowerOn
);

`ifdef SOUND_READMASK_EN
    localparam logic [7:0] RM10 = SND_NR10_RMASK;
    localparam logic [7:0] RM11 = SND_NR11_RMASK;
    localparam logic [7:0] RM12 = SND_NR12_RMASK;
    localparam logic [7:0] RM13 = SND_NR13_RMASK;
    localparam logic [7:0] RM14 = SND_NR14_RMASK;
    localparam logic [7:0] RM50 = SND_NR50_RMASK;
    localparam logic [7:0] RM51 = SND_NR51_RMASK;
`else
    localparam logic [7:0] RM10 = 8'h00;
    localparam logic [7:0] RM11 = 8'h00;
    localparam logic [7:0] RM12 = 8'h00;
    localparam logic [7:0] RM13 = 8'h00;
    localparam logic [7:0] RM14 = 8'h00;
    localparam logic [7:0] RM50 = 8'h00;
    localparam logic [7:0] RM51 = 8'h00;
`endif

    logic [7:0] r_nr10;
    logic [7:0] r_nr11;
    logic [7:0] r_nr12;
    logic [7:0] r_nr13;
    logic [6:0] r_nr14;
    logic [7:0] r_nr50;
    logic [7:0] r_nr51;
    logic       r_power;
    logic [7:0] r_data;

    logic       w_wr_nr52;
    logic       w_wr_nr14;
    logic       w_wr_en;
    logic       w_trig;
    logic [7:0] w_rdata;

    assign w_wr_nr52 = iWe && (iAddr == SND_NR52_ADDR);
    assign w_wr_nr14 = iWe && (iAddr == SND_NR14_ADDR);
    assign w_wr_en   = iWe && r_power;

    // NR52 is always writable; a power-off write wipes the rest on the same edge.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_nr10  <= 8'h00;
            r_nr11  <= 8'h00;
            r_nr12  <= 8'h00;
            r_nr13  <= 8'h00;
            r_nr14  <= 7'h00;
            r_nr50  <= 8'h00;
            r_nr51  <= 8'h00;
            r_power <= 1'b0;
        end else if (w_wr_nr52) begin
            r_power <= iData[7];
            if (!iData[7]) begin
                r_nr10 <= 8'h00;
                r_nr11 <= 8'h00;
                r_nr12 <= 8'h00;
                r_nr13 <= 8'h00;
                r_nr14 <= 7'h00;
                r_nr50 <= 8'h00;
                r_nr51 <= 8'h00;
            end
        end else if (w_wr_en) begin
            case (iAddr)
                SND_NR10_ADDR: r_nr10 <= iData;
                SND_NR11_ADDR: r_nr11 <= iData;
                SND_NR12_ADDR: r_nr12 <= iData;
                SND_NR13_ADDR: r_nr13 <= iData;
                SND_NR14_ADDR: r_nr14 <= iData[6:0];
                SND_NR50_ADDR: r_nr50 <= iData;
                SND_NR51_ADDR: r_nr51 <= iData;
                default: ;
            endcase
        end
    end

    sound_trigger_pulse u_trig (
        .i_clk    (iClock),
        .i_reset  (iReset),
        .i_strobe (w_wr_nr14),
        .i_bit    (iData[7]),
        .i_power  (r_power),
        .o_pulse  (w_trig)
    );

    always_comb begin
        w_rdata = SND_UNMAPPED;
        case (iAddr)
            SND_NR10_ADDR: w_rdata = r_nr10 | RM10;
            SND_NR11_ADDR: w_rdata = r_nr11 | RM11;
            SND_NR12_ADDR: w_rdata = r_nr12 | RM12;
            SND_NR13_ADDR: w_rdata = r_nr13 | RM13;
            SND_NR14_ADDR: w_rdata = {1'b0, r_nr14} | RM14;
            SND_NR50_ADDR: w_rdata = r_nr50 | RM50;
            SND_NR51_ADDR: w_rdata = r_nr51 | RM51;
            SND_NR52_ADDR: w_rdata = {r_power, SND_NR52_RSVD, iCh1On};
            default:       w_rdata = SND_UNMAPPED;
        endcase
    end

    always_ff @(posedge iClock) begin
        if (iReset)
            r_data <= SND_UNMAPPED;
        else
            r_data <= w_rdata;
    end

    assign oData    = r_data;
    assign oNR10    = r_nr10;
    assign oNR11    = r_nr11;
    assign oNR12    = r_nr12;
    assign oNR13    = r_nr13;
    assign oNR14    = {w_trig, r_nr14};
    assign oNR50    = r_nr50;
    assign oNR51    = r_nr51;
    assign oPowerOn = r_power;

endmodule

// File: tb/tb_sound_ch1_regfile.sv
// Randomized bench for sound_ch1_regfile against a register-map reference model.
// Build with SOUND_READMASK_EN to check the masked read variant.
module tb_sound_ch1_regfile;

    logic        iClock = 1'b0;
    logic        iReset = 1'b1;
    logic [15:0] iAddr = 16'h0000;
    logic        iWe = 1'b0;
    logic [7:0]  iData = 8'h00;
    logic        iCh1On = 1'b0;
    logic [7:0]  oData;
    logic [7:0]  oNR10, oNR11, oNR12, oNR13, oNR14, oNR50, oNR51;
    logic        oPowerOn;

    sound_ch1_regfile dut (
        .iClock   (iClock),
        .iReset   (iReset),
        .iAddr    (iAddr),
        .iWe      (iWe),
        .iData    (iData),
        .oData    (oData),
        .oNR10    (oNR10),
        .oNR11    (oNR11),
        .oNR12    (oNR12),
        .oNR13    (oNR13),
        .oNR14    (oNR14),
        .oNR50    (oNR50),
        .oNR51    (oNR51),
        .iCh1On   (iCh1On),
        .oPowerOn (oPowerOn)
    );

    always #5 iClock = ~iClock;

    int n_checks = 0;
    int n_errors = 0;

    // model: stored byte per mapped register, in address order 10..14,24,25
    logic [15:0] m_addr [7] = '{16'hFF10, 16'hFF11, 16'hFF12,
                                16'hFF13, 16'hFF14, 16'hFF24, 16'hFF25};
`ifdef SOUND_READMASK_EN
    logic [7:0] m_mask [7] = '{8'h80, 8'h3F, 8'h00, 8'hFF, 8'hBF, 8'h00, 8'h00};
`else
    logic [7:0] m_mask [7] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
    logic [7:0] m_reg [7];
    bit         m_pow;
    bit         m_trig;
    logic [7:0] m_data;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int reg_idx(input logic [15:0] a);
        for (int i = 0; i < 7; i++)
            if (m_addr[i] == a) return i;
        return -1;
    endfunction

    function automatic logic [7:0] model_read(input logic [15:0] a, input bit ch1);
        int k = reg_idx(a);
        if (a == 16'hFF26) return (m_pow ? 8'hF0 : 8'h70) | {7'd0, ch1};
        if (k < 0) return 8'hFF;
        return m_reg[k] | m_mask[k];
    endfunction

    task automatic step(input logic [15:0] a, input bit we, input logic [7:0] d,
                        input bit ch1, input bit rst);
        int k;
        iAddr = a; iWe = we; iData = d; iCh1On = ch1; iReset = rst;
        k = reg_idx(a);
        if (rst) begin
            foreach (m_reg[i]) m_reg[i] = 8'h00;
            m_pow = 0; m_trig = 0; m_data = 8'hFF;
        end else begin
            m_data = model_read(a, ch1);
            m_trig = 0;
            if (we && a == 16'hFF26) begin
                if (!d[7]) foreach (m_reg[i]) m_reg[i] = 8'h00;
                m_pow = d[7];
            end else if (we && m_pow && k >= 0) begin
                m_reg[k] = (k == 4) ? {1'b0, d[6:0]} : d;
                m_trig = (k == 4) && d[7];
            end
        end
        @(posedge iClock);
        #1;
        check("oData", oData, m_data);
        check("oNR10", oNR10, m_reg[0]);
        check("oNR11", oNR11, m_reg[1]);
        check("oNR12", oNR12, m_reg[2]);
        check("oNR13", oNR13, m_reg[3]);
        check("oNR14", oNR14, {m_trig, m_reg[4][6:0]});
        check("oNR50", oNR50, m_reg[5]);
        check("oNR51", oNR51, m_reg[6]);
        check("oPowerOn", {7'd0, oPowerOn}, {7'd0, m_pow});
    endtask

    logic [15:0] pick;
    logic [7:0]  dat;

    initial begin
        step(16'h0000, 0, 8'h00, 0, 1);
        check("rst_data", oData, 8'hFF);
        step(16'hFF26, 0, 8'h00, 1, 0);
        check("nr52_off", oData, 8'h71);

        step(16'hFF26, 1, 8'h80, 0, 0);
        step(16'hFF12, 1, 8'hF3, 0, 0);
        check("nr12_wr", oNR12, 8'hF3);
        step(16'hFF12, 0, 8'h00, 0, 0);
        check("nr12_rd", oData, 8'hF3);

        step(16'hFF14, 1, 8'h87, 0, 0);
        check("trig_hi", oNR14, 8'h87);
        step(16'hFF14, 0, 8'h00, 0, 0);
        check("trig_lo", oNR14, 8'h07);
`ifdef SOUND_READMASK_EN
        check("nr14_rd", oData, 8'hBF);
`else
        check("nr14_rd", oData, 8'h07);
`endif

        step(16'hFF14, 1, 8'h80, 0, 0);
        check("b2b_1", {7'd0, oNR14[7]}, 8'h01);
        step(16'hFF14, 1, 8'h80, 0, 0);
        check("b2b_2", {7'd0, oNR14[7]}, 8'h01);
        step(16'hFF10, 1, 8'h80, 0, 0);
        check("b2b_end", {7'd0, oNR14[7]}, 8'h00);

        step(16'hFF11, 1, 8'h80, 0, 0);
        step(16'hFF26, 1, 8'h00, 0, 0);
        check("off_nr11", oNR11, 8'h00);
        check("off_pow", {7'd0, oPowerOn}, 8'h00);
        step(16'hFF13, 1, 8'h55, 0, 0);
        check("off_nr13", oNR13, 8'h00);
        step(16'hFF14, 1, 8'h80, 0, 0);
        check("off_trig", oNR14, 8'h00);

        step(16'hFF26, 1, 8'h80, 0, 0);
        step(16'hFF14, 1, 8'h80, 0, 0);
        step(16'hFF14, 1, 8'h80, 0, 1);
        check("rst_trig", oNR14, 8'h00);
        check("rst_pow", {7'd0, oPowerOn}, 8'h00);

        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 11))
                0, 1:    pick = 16'hFF26;
                2:       pick = 16'hFF24;
                3:       pick = 16'hFF25;
                4:       pick = 16'hFF15;
                5:       pick = 16'hFF27;
                6:       pick = 16'($urandom);
                default: pick = 16'hFF10 + 16'($urandom_range(0, 4));
            endcase
            dat = 8'($urandom);
            if (pick == 16'hFF26 && $urandom_range(0, 3) != 0) dat[7] = 1'b1;
            step(pick, $urandom_range(0, 2) != 0, dat, 1'($urandom),
                 $urandom_range(0, 60) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
